// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter on the CPU data-memory bus.
//
// A 16-byte window at BASE_ADDR holds four word registers selected by a[3:2]:
//   0 TXDATA  write pushes wd[7:0] into the byte FIFO, reads 0
//   1 STATUS  {16'b0, count[7:0], 5'b0, busy, empty, full}, read-only
//   2 DROPS   {24'b0, drop_cnt}; any write clears drop_cnt
//   3 reserved, reads 0, writes ignored
// Reads are combinational (same timing as dmem); rd is 0 outside the window.
//
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high
//   we       bus write strobe
//   a        byte address
//   wd       write data
//   rd       combinational read data
//   sel      combinational window hit (a[31:4] == BASE_ADDR[31:4])
//   tx       registered serial line, idle high
//   busy     registered, high while the transmitter is not idle
//   state_o  debug view of the transmit FSM: 0 IDLE, 1 START, 2 DATA, 3 STOP
//
// Handshake: there is no back-pressure on the bus. A write to TXDATA is
// accepted on the clock edge where we=1 if the FIFO has room or a byte is
// popped on that same edge; otherwise the byte is dropped and counted.
module mmio_uart_tx #(
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_DEPTH   = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   output logic [31:0] rd,
   output logic        sel,
   output logic        tx,
   output logic        busy,
   output logic [1:0]  state_o
);

   localparam int          PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [7:0]  DEPTH_C   = 8'(FIFO_DEPTH);
   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [15:0]       baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic [7:0]        count_q, count_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [7:0]        drop_q, drop_d;
   logic [7:0]        mem [FIFO_DEPTH];

   logic [1:0] off;
   logic       push_req;
   logic       push_ok;
   logic       drop_clr;
   logic       pop;
   logic       fifo_full;
   logic       fifo_empty;
   logic       baud_done;

   // Byte-lane and sub-word address bits carry no meaning for this block.
   logic unused_bits;
   assign unused_bits = ^{a[1:0], wd[31:8]};

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   assign sel        = (a[31:4] == BASE_ADDR[31:4]);
   assign off        = a[3:2];
   assign push_req   = we & sel & (off == 2'd0);
   assign drop_clr   = we & sel & (off == 2'd2);
   assign fifo_full  = (count_q == DEPTH_C);
   assign fifo_empty = (count_q == 8'd0);
   assign baud_done  = (baud_q == BAUD_LAST);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         baud_q   <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         count_q  <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         drop_q   <= '0;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         count_q  <= count_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         drop_q   <= drop_d;
      end
   end

   // FIFO storage needs no reset: an entry is only read after it was written.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_q] <= wd[7:0];
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      baud_d  = baud_done ? 16'd0 : baud_q + 16'd1;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      case (state_q)
         S_IDLE: begin
            baud_d = 16'd0;
            if (!fifo_empty) begin
               pop     = 1'b1;
               shift_d = mem[rd_ptr_q];
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_done) begin
               state_d = S_DATA;
               bit_d   = 3'd0;
            end
         end
         S_DATA: begin
            if (baud_done) begin
               if (bit_q == 3'd7) begin
                  state_d = S_STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         S_STOP: begin
            // Pop straight into the next start bit so queued bytes leave
            // with no idle gap between frames.
            if (baud_done) begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = mem[rd_ptr_q];
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output logic. tx and busy are registered, so they are computed
   // from the next state to line up with the state they describe.
   // ------------------------------------------------------------------
   always_comb begin
      tx_d   = 1'b1;
      busy_d = (state_d != S_IDLE);
      case (state_d)
         S_IDLE:  tx_d = 1'b1;
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[bit_d];
         S_STOP:  tx_d = 1'b1;
         default: tx_d = 1'b1;
      endcase
   end

   // ------------------------------------------------------------------
   // FIFO pointers, occupancy and drop counter
   // ------------------------------------------------------------------
   always_comb begin
      // A pop on the same edge frees the slot the push needs.
      push_ok  = push_req & (!fifo_full | pop);
      wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q;
      case ({push_ok, pop})
         2'b10:   count_d = count_q + 8'd1;
         2'b01:   count_d = count_q - 8'd1;
         default: count_d = count_q;
      endcase
      drop_d = drop_q;
      if (drop_clr) begin
         drop_d = 8'd0;
      end else if (push_req && !push_ok && (drop_q != 8'hFF)) begin
         drop_d = drop_q + 8'd1;
      end
   end

   // ------------------------------------------------------------------
   // Combinational read mux
   // ------------------------------------------------------------------
   always_comb begin
      rd = 32'd0;
      if (sel) begin
         case (off)
            2'd1:    rd = {16'd0, count_q, 5'd0, busy_q, fifo_empty, fifo_full};
            2'd2:    rd = {24'd0, drop_q};
            default: rd = 32'd0;
         endcase
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign state_o = state_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: self-checking bench for mmio_uart_tx (CLKS_PER_BIT=4,
// FIFO_DEPTH=8). A frame-level reference model predicts tx, busy and the
// register reads every cycle; a line decoder turns tx back into bytes and
// compares them with the bytes the model says were sent.
module tb_mmio_uart_tx;

   localparam logic [31:0] BASE  = 32'h0000_0100;
   localparam int          CPB   = 4;
   localparam int          DEPTH = 8;
   localparam int          FRAME = 10 * CPB;

   logic        clk = 1'b0;
   logic        reset;
   logic        we;
   logic [31:0] a;
   logic [31:0] wd;
   logic [31:0] rd;
   logic        sel;
   logic        tx;
   logic        busy;
   logic [1:0]  dbg_state;

   mmio_uart_tx #(
      .BASE_ADDR   (BASE),
      .CLKS_PER_BIT(CPB),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .we     (we),
      .a      (a),
      .wd     (wd),
      .rd     (rd),
      .sel    (sel),
      .tx     (tx),
      .busy   (busy),
      .state_o(dbg_state)
   );

   // ------------------------------------------------------------------
   // Clock
   // ------------------------------------------------------------------
   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int busy_cycles = 0;

   // ------------------------------------------------------------------
   // Reference model: queue of buffered bytes, cycles left in the current
   // frame, the byte on the line, and the drop count.
   // ------------------------------------------------------------------
   logic [7:0] m_fifo[$];
   int         m_rem;
   logic [7:0] m_cur;
   int         m_drops;
   logic [7:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_fifo.delete();
      exp_q.delete();
      m_rem   = 0;
      m_cur   = 8'h00;
      m_drops = 0;
   endtask

   function automatic logic m_sel(input logic [31:0] addr);
      return addr[31:4] == BASE[31:4];
   endfunction

   function automatic logic m_tx();
      int p;
      int slot;
      if (m_rem == 0) return 1'b1;
      p    = FRAME - m_rem;
      slot = p / CPB;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return m_cur[slot-1];
      return 1'b1;
   endfunction

   function automatic logic [31:0] m_rd(input logic [31:0] addr);
      int n;
      n = m_fifo.size();
      if (!m_sel(addr)) return 32'd0;
      case (addr[3:2])
         2'd1:    return {16'd0, 8'(n), 5'd0, (m_rem > 0), (n == 0), (n == DEPTH)};
         2'd2:    return {24'd0, 8'(m_drops)};
         default: return 32'd0;
      endcase
   endfunction

   // One clock edge of the model, using the inputs present at that edge.
   task automatic model_step();
      int  pre;
      logic pop;
      logic push_req;
      logic clr;
      pre      = m_fifo.size();
      pop      = (m_rem <= 1) && (pre > 0);
      push_req = we && m_sel(a) && (a[3:2] == 2'd0);
      clr      = we && m_sel(a) && (a[3:2] == 2'd2);
      if (m_rem > 0) m_rem--;
      if (pop) begin
         m_cur = m_fifo.pop_front();
         m_rem = FRAME;
         exp_q.push_back(m_cur);
      end
      if (push_req) begin
         if (pre < DEPTH || pop) m_fifo.push_back(wd[7:0]);
         else if (m_drops < 255) m_drops++;
      end
      if (clr) m_drops = 0;
   endtask

   // ------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      #1;
      check("tx", tx, m_tx());
      check("busy", busy, m_rem > 0);
      check("dbg_idle", dbg_state == 2'd0, m_rem == 0);
      if (busy) busy_cycles++;
   endtask

   task automatic write(input logic [31:0] addr, input logic [31:0] data);
      a  = addr;
      wd = data;
      we = 1'b1;
      tick();
      we = 1'b0;
      a  = 32'd0;
   endtask

   task automatic read_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
      a  = addr;
      we = 1'b0;
      #1;
      check(name, rd, exp);
   endtask

   task automatic run_idle(input int limit);
      int n;
      n = 0;
      while ((m_rem > 0 || m_fifo.size() > 0) && n < limit) begin
         tick();
         n++;
      end
      checks++;
      if (n < limit) passes++;
      else $display("FAIL idle_timeout: still busy after %0d cycles", n);
      tick();
      tick();
   endtask

   // ------------------------------------------------------------------
   // Line decoder / scoreboard: samples mid-bit, compares with exp_q.
   // ------------------------------------------------------------------
   int         dec_pos = -1;
   logic [7:0] dec_byte = 8'h00;

   always @(posedge clk) begin
      #1;
      if (reset) begin
         dec_pos = -1;
      end else if (dec_pos < 0) begin
         if (tx == 1'b0) begin
            dec_pos  = 0;
            dec_byte = 8'h00;
         end
      end else begin
         dec_pos++;
         if ((dec_pos % CPB) == CPB / 2 && dec_pos / CPB >= 1 && dec_pos / CPB <= 8)
            dec_byte[dec_pos/CPB-1] = tx;
         if (dec_pos == FRAME - 1) begin
            check("stop_bit", tx, 1'b1);
            checks++;
            if (exp_q.size() == 0) begin
               $display("FAIL rx_unexpected: decoded 0x%02h with nothing expected", dec_byte);
            end else begin
               logic [7:0] e;
               e = exp_q.pop_front();
               if (dec_byte === e) passes++;
               else $display("FAIL rx_byte: got 0x%02h expected 0x%02h", dec_byte, e);
            end
            dec_pos = -1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Decode vectors
   // ------------------------------------------------------------------
   typedef struct {
      logic        we;
      logic [31:0] a;
      logic [31:0] wd;
      logic        exp_sel;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, BASE + 32'h0, 32'h0,        1'b1, 32'h0};
      vecs[1]  = '{1'b0, BASE + 32'h4, 32'h0,        1'b1, 32'h2};
      vecs[2]  = '{1'b0, BASE + 32'h8, 32'h0,        1'b1, 32'h0};
      vecs[3]  = '{1'b0, BASE + 32'hC, 32'h0,        1'b1, 32'h0};
      vecs[4]  = '{1'b0, BASE + 32'h7, 32'h0,        1'b1, 32'h2};
      vecs[5]  = '{1'b1, 32'h0000_0040, 32'hFF,      1'b0, 32'h0};
      vecs[6]  = '{1'b1, BASE + 32'hC, 32'h77,       1'b1, 32'h0};
      vecs[7]  = '{1'b1, BASE + 32'h4, 32'hFFFF,     1'b1, 32'h2};
      vecs[8]  = '{1'b0, 32'h0000_0110, 32'h0,       1'b0, 32'h0};
      vecs[9]  = '{1'b0, 32'h0000_00F0, 32'h0,       1'b0, 32'h0};
      vecs[10] = '{1'b1, 32'h0000_1100, 32'h42,      1'b0, 32'h0};

      // Reset
      reset = 1'b1;
      we    = 1'b0;
      a     = 32'd0;
      wd    = 32'd0;
      model_reset();
      tick();
      tick();
      check("reset_tx", tx, 1'b1);
      check("reset_busy", busy, 1'b0);
      read_check("reset_status", BASE + 32'h4, 32'h0000_0002);
      read_check("reset_drops", BASE + 32'h8, 32'h0000_0000);
      reset = 1'b0;
      tick();

      // Decode table
      for (int i = 0; i < 11; i++) begin
         a  = vecs[i].a;
         we = vecs[i].we;
         wd = vecs[i].wd;
         #1;
         check($sformatf("vec%0d_sel", i), sel, vecs[i].exp_sel);
         check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
         tick();
         we = 1'b0;
      end
      read_check("decode_status", BASE + 32'h4, 32'h0000_0002);

      // Single byte 0x55
      busy_cycles = 0;
      write(BASE, 32'h0000_0055);
      read_check("single_status_n", BASE + 32'h4, 32'h0000_0100);
      tick();
      read_check("single_status_n1", BASE + 32'h4, 32'h0000_0006);
      run_idle(200);
      check("single_busy_len", busy_cycles, 40);

      // Back-to-back 0xA5, 0x3C
      busy_cycles = 0;
      write(BASE, 32'h0000_00A5);
      write(BASE, 32'h0000_003C);
      run_idle(300);
      check("b2b_busy_len", busy_cycles, 80);

      // Overflow: 0x01..0x0A on consecutive edges
      for (int i = 1; i <= 10; i++) write(BASE, 32'(i));
      read_check("ovf_status", BASE + 32'h4, 32'h0000_0805);
      read_check("ovf_drops", BASE + 32'h8, 32'h0000_0001);
      write(BASE + 32'h8, 32'h0);
      read_check("ovf_drops_clr", BASE + 32'h8, 32'h0000_0000);
      run_idle(1000);

      // Reset mid-frame during DATA bit 3 with 2 bytes queued
      write(BASE, 32'h11);
      write(BASE, 32'h22);
      write(BASE, 32'h33);
      begin
         int n;
         n = 0;
         while (m_rem != FRAME - 4 * CPB && n < 100) begin
            tick();
            n++;
         end
         checks++;
         if (n < 100) passes++;
         else $display("FAIL midreset_wait: bit 3 not reached after %0d cycles", n);
      end
      read_check("midreset_pre_status", BASE + 32'h4, 32'h0000_0204);
      reset = 1'b1;
      model_reset();
      #1;
      check("midreset_tx", tx, 1'b1);
      check("midreset_busy", busy, 1'b0);
      read_check("midreset_status", BASE + 32'h4, 32'h0000_0002);
      tick();
      reset = 1'b0;
      tick();
      busy_cycles = 0;
      write(BASE, 32'h0000_005A);
      run_idle(200);
      check("midreset_busy_len", busy_cycles, 40);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 9) < 7) begin
            a = BASE + 32'($urandom_range(0, 15));
         end else begin
            a = $urandom;
            if (a[31:4] == BASE[31:4]) a = a ^ 32'h1000_0000;
         end
         we = ($urandom_range(0, 9) < 5);
         wd = $urandom;
         #1;
         check("rand_sel", sel, m_sel(a));
         check("rand_rd", rd, m_rd(a));
         tick();
      end
      we = 1'b0;
      a  = 32'd0;
      run_idle(5000);
      tick();

      check("all_bytes_decoded", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter. It is a responder on the CPU data-memory bus and sits beside dmem.
- It decodes a 16-byte window at BASE_ADDR, buffers written bytes in a FIFO and serializes them as 8N1 frames on tx.
- Reads are combinational, with the same timing as dmem. The top level selects rd onto ReadDataM when sel=1.

Parameters:
- BASE_ADDR, 32'h0000_0100: window base, 16-byte aligned; lies outside the 64-word dmem range.
- CLKS_PER_BIT, 434: clk cycles per bit (50 MHz / 115200 baud); legal range 2..65535.
- FIFO_DEPTH, 8: byte entries; power of 2, legal range 2..128.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- we  input  1  bus write strobe (MemWriteM).
- a  input  32  byte address (ALUResultM).
- wd  input  32  write data (WriteDataM).
- rd  output  32  read data, combinational.
- sel  output  1  combinational; 1 when a[31:4]==BASE_ADDR[31:4].
- tx  output  1  serial line, registered, idle high.
- busy  output  1  registered; 1 when FSM not in IDLE.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clk is the clock.
- Reset state, applied immediately including mid-frame:
  - tx=1, busy=0, FSM=IDLE.
  - FIFO empty, read/write pointers 0.
  - drop counter 0, shift register and baud/bit counters 0.
- Address decode:
  - Offset is a[3:2]; a[1:0] are ignored.
  - Accesses with sel=0 have no effect, and rd=0 when sel=0.
- Offset 0, TXDATA:
  - Write at a posedge with we=1 pushes wd[7:0].
  - Read returns 0.
- Offset 1, STATUS (read-only; writes ignored):
  - bit0 full, bit1 empty, bit2 busy.
  - bits[15:8] FIFO count (0..FIFO_DEPTH); all other bits 0.
- Offset 2, DROPS:
  - Read returns {24'b0, drop_cnt}.
  - Any write clears drop_cnt to 0.
- Offset 3: reserved; reads 0, writes ignored.
- Push acceptance:
  - A push is accepted when count<FIFO_DEPTH, or when a pop occurs on the same edge.
  - Otherwise the byte is discarded and drop_cnt increments, saturating at 255.
  - A simultaneous push and pop leaves count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP. The baud counter counts CLKS_PER_BIT cycles per bit.
- IDLE:
  - tx=1.
  - If FIFO not empty (registered count>0): pop head into shift register, go to START, clear baud counter.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - tx=shift[bit index] for CLKS_PER_BIT cycles per bit, LSB first.
  - After bit 7, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - At the end, if FIFO not empty: pop and go directly to START (back-to-back, no idle gap). Else go to IDLE.
- Timing:
  - A push at edge N into an empty, idle block gives pop at edge N+1; tx falls after edge N+1.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - busy is high from edge N+1 until the last STOP cycle completes.
- Ordering: bytes are transmitted in write order. A dropped byte never appears on tx.
- Width rules:
  - Count register is 8 bits wide.
  - Baud counter is 16 bits; it compares against CLKS_PER_BIT-1 and wraps to 0.

Test Plan:
- Bench uses CLKS_PER_BIT=4 and FIFO_DEPTH=8 unless stated.
- Reset: assert reset -> tx=1, busy=0; read BASE+4 gives 32'h0000_0002; read BASE+8 gives 0.
- Single byte: write 32'h0000_0055 to BASE at edge N.
  - Expected tx: low for cycles N+1..N+4, then bits 1,0,1,0,1,0,1,0 for 4 cycles each, then high for 4 cycles.
  - busy high for exactly 40 cycles; STATUS count reads 1 after N, 0 after N+1.
- Back-to-back: write 0xA5 then 0x3C on consecutive cycles.
  - Expected: 80 contiguous cycles of framing; start bit of 0x3C immediately follows stop bit of 0xA5.
  - Decoded bytes are A5, 3C.
- Overflow: 10 writes of 0x01..0x0A on consecutive edges.
  - Expected: 0x01 popped on the second edge; 0x0A dropped.
  - STATUS reads full=1 with count=8; DROPS reads 1.
  - tx carries 0x01..0x09 in order. Write to BASE+8, then DROPS reads 0.
- Decode: write to 32'h0000_0040 and to BASE+0xC.
  - Expected: sel=0 for 0x40 and sel=1 for BASE+0xC.
  - FIFO count stays 0 for both; rd=0 for both; tx stays 1.
- Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued.
  - Expected: tx=1 and busy=0 immediately; STATUS reads 0x0000_0002.
  - A following write of 0x5A produces one clean 40-cycle frame.
